// File: rtl/acc_multi_pkg.sv
// Shared types for the multi-channel accelerator dispatcher: queue entry layout,
// memory-counter type and the saturating-free counter update helper.
package acc_multi_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned MEM_CNT_WIDTH = 3;

  typedef struct packed {
    logic [31:0]              insn;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     is_load;
    logic                     is_store;
  } acc_queue_entry_t;

  typedef logic [MEM_CNT_WIDTH-1:0] acc_mem_cnt_t;

  // Simultaneous inc and dec cancel; range violations are caught by assertions.
  function automatic acc_mem_cnt_t cnt_next(acc_mem_cnt_t cnt, logic inc, logic dec);
    return cnt + acc_mem_cnt_t'(inc) - acc_mem_cnt_t'(dec);
  endfunction

endpackage

// File: rtl/acc_chan_queue.sv
// One channel's fall-through instruction FIFO plus its speculative and
// dispatched load/store counters. push_i must already exclude flush cycles.
module acc_chan_queue
  import acc_multi_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  localparam int unsigned PtrW      = (QueueDepth > 1) ? $clog2(QueueDepth) : 1,
  localparam int unsigned UsageW    = $clog2(QueueDepth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  acc_queue_entry_t push_entry_i,
  input  logic             pop_i,
  input  logic             load_complete_i,
  input  logic             store_complete_i,
  output acc_queue_entry_t head_o,
  output logic             head_valid_o,
  output logic [UsageW-1:0] usage_o,
  output logic             ld_busy_o,
  output logic             st_busy_o
);

  acc_queue_entry_t  mem_q [QueueDepth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [UsageW-1:0] usage_q, usage_d;
  acc_mem_cnt_t      spec_ld_q, spec_ld_d, spec_st_q, spec_st_d;
  acc_mem_cnt_t      disp_ld_q, disp_ld_d, disp_st_q, disp_st_d;
  logic              empty, bypass, write_en;
  logic              push_ld, push_st, pop_ld, pop_st;

  assign empty        = (usage_q == '0);
  assign head_valid_o = !empty || push_i;
  assign head_o       = !empty ? mem_q[rd_ptr_q] : (push_i ? push_entry_i : '0);
  // A push into an empty queue that is popped in the same cycle never lands in storage.
  assign bypass       = empty && push_i && pop_i;
  assign write_en     = push_i && !bypass;
  assign usage_o      = usage_q;

  assign push_ld = push_i && push_entry_i.is_load;
  assign push_st = push_i && push_entry_i.is_store;
  assign pop_ld  = pop_i && head_o.is_load;
  assign pop_st  = pop_i && head_o.is_store;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (write_en)
        wr_ptr_d = (int'(wr_ptr_q) == QueueDepth - 1) ? '0 : wr_ptr_q + 1'b1;
      if (pop_i && !bypass)
        rd_ptr_d = (int'(rd_ptr_q) == QueueDepth - 1) ? '0 : rd_ptr_q + 1'b1;
      usage_d = usage_q + UsageW'(push_i) - UsageW'(pop_i);
    end
  end

  always_comb begin
    spec_ld_d = flush_i ? '0 : cnt_next(spec_ld_q, push_ld, pop_ld);
    spec_st_d = flush_i ? '0 : cnt_next(spec_st_q, push_st, pop_st);
    disp_ld_d = cnt_next(disp_ld_q, pop_ld, load_complete_i);
    disp_st_d = cnt_next(disp_st_q, pop_st, store_complete_i);
  end

  assign ld_busy_o = (spec_ld_q != '0) || (disp_ld_q != '0);
  assign st_busy_o = (spec_st_q != '0) || (disp_st_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      usage_q   <= '0;
      spec_ld_q <= '0;
      spec_st_q <= '0;
      disp_ld_q <= '0;
      disp_st_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      usage_q   <= usage_d;
      spec_ld_q <= spec_ld_d;
      spec_st_q <= spec_st_d;
      disp_ld_q <= disp_ld_d;
      disp_st_q <= disp_st_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_en) mem_q[wr_ptr_q] <= push_entry_i;
  end

  a_spec_ld_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_ld && !pop_ld && !flush_i && spec_ld_q == '1));
  a_spec_ld_unf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_ld && !push_ld && !flush_i && spec_ld_q == '0));
  a_spec_st_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_st && !pop_st && !flush_i && spec_st_q == '1));
  a_spec_st_unf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_st && !push_st && !flush_i && spec_st_q == '0));
  a_disp_ld_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_ld && !load_complete_i && disp_ld_q == '1));
  a_disp_ld_unf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(load_complete_i && !pop_ld && disp_ld_q == '0));
  a_disp_st_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_st && !store_complete_i && disp_st_q == '1));
  a_disp_st_unf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(store_complete_i && !pop_st && disp_st_q == '0));

endmodule

// File: rtl/acc_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searching upward from ptr_q,
// pointer advances to grant+1 after every grant.
module acc_rr_arb #(
  parameter int unsigned NumIn     = 2,
  parameter int unsigned DataWidth = 8,
  localparam int unsigned IdxW     = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumIn-1:0]           req_i,
  input  logic [NumIn*DataWidth-1:0] data_i,
  output logic [NumIn-1:0]           gnt_o,
  output logic                       valid_o,
  output logic [DataWidth-1:0]       data_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] cand;
  int unsigned     sum;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    gnt_idx = '0;
    data_o  = '0;
    cand    = '0;
    sum     = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= NumIn) sum = sum - NumIn;
      cand = IdxW'(sum);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        gnt_idx = cand;
      end
    end
    if (valid_o) begin
      gnt_o[gnt_idx] = 1'b1;
      data_o         = data_i[int'(gnt_idx)*DataWidth +: DataWidth];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (valid_o) ptr_d = (int'(gnt_idx) == NumIn - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/acc_multi_dispatcher.sv
// Routes issued accelerator instructions to NrAcc channel queues, releases each
// once committed, and merges channel responses onto one writeback port.
// Handshakes: a transfer happens in a cycle where valid and ready are both high;
// valid never waits on ready, and payload holds while valid && !ready.
module acc_multi_dispatcher
  import acc_multi_pkg::*;
#(
  parameter int unsigned NrAcc       = 2,
  parameter int unsigned QueueDepth  = 4,
  parameter int unsigned NrSbEntries = 8,
  parameter int unsigned TransIdBits = TRANS_ID_BITS,
  parameter int unsigned XLen        = XLEN,
  parameter int unsigned MemCntWidth = MEM_CNT_WIDTH,
  localparam int unsigned AccIdW     = (NrAcc > 1) ? $clog2(NrAcc) : 1,
  localparam int unsigned UsageW     = $clog2(QueueDepth + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [AccIdW-1:0]            issue_acc_id_i,
  input  logic [TransIdBits-1:0]       issue_trans_id_i,
  input  logic [31:0]                  issue_insn_i,
  input  logic [XLen-1:0]              issue_rs1_i,
  input  logic [XLen-1:0]              issue_rs2_i,
  input  logic                         issue_is_load_i,
  input  logic                         issue_is_store_i,
  input  logic                         commit_valid_i,
  input  logic [TransIdBits-1:0]       commit_trans_id_i,
  output logic [NrAcc-1:0]             acc_req_valid_o,
  input  logic [NrAcc-1:0]             acc_req_ready_i,
  output logic [NrAcc*32-1:0]          acc_req_insn_o,
  output logic [NrAcc*XLen-1:0]        acc_req_rs1_o,
  output logic [NrAcc*XLen-1:0]        acc_req_rs2_o,
  output logic [NrAcc*TransIdBits-1:0] acc_req_trans_id_o,
  input  logic [NrAcc-1:0]             acc_resp_valid_i,
  output logic [NrAcc-1:0]             acc_resp_ready_o,
  input  logic [NrAcc*TransIdBits-1:0] acc_resp_trans_id_i,
  input  logic [NrAcc*XLen-1:0]        acc_resp_result_i,
  input  logic [NrAcc-1:0]             acc_load_complete_i,
  input  logic [NrAcc-1:0]             acc_store_complete_i,
  output logic                         wb_valid_o,
  output logic [TransIdBits-1:0]       wb_trans_id_o,
  output logic [XLen-1:0]              wb_result_o,
  output logic                         ld_pending_o,
  output logic                         st_pending_o
);

  localparam int unsigned RespW = TransIdBits + XLen;

  logic [NrSbEntries-1:0]  pending_q, pending_d, ready_q, ready_d;
  acc_queue_entry_t        issue_entry;
  acc_queue_entry_t        head [NrAcc];
  logic [UsageW-1:0]       usage [NrAcc];
  logic [NrAcc-1:0]        head_valid, push, pop, req_valid, ld_busy, st_busy;
  logic [NrAcc*RespW-1:0]  resp_data;
  logic                    commit_hit, push_ok;

  assign issue_ready_o = usage[issue_acc_id_i] < UsageW'(QueueDepth);
  assign push_ok       = issue_valid_i && issue_ready_o && !flush_i;
  assign commit_hit    = commit_valid_i && pending_q[commit_trans_id_i];

  assign issue_entry = '{insn: issue_insn_i, rs1: issue_rs1_i, rs2: issue_rs2_i,
                         trans_id: issue_trans_id_i, is_load: issue_is_load_i,
                         is_store: issue_is_store_i};

  for (genvar c = 0; c < NrAcc; c++) begin : g_chan
    assign push[c]      = push_ok && (issue_acc_id_i == AccIdW'(c));
    // A commit of the head ID releases it in the same cycle it arrives.
    assign req_valid[c] = head_valid[c] &&
                          (ready_q[head[c].trans_id] ||
                           (commit_hit && commit_trans_id_i == head[c].trans_id));
    assign pop[c]       = req_valid[c] && acc_req_ready_i[c];

    assign acc_req_insn_o[c*32 +: 32]                    = head[c].insn;
    assign acc_req_rs1_o[c*XLen +: XLen]                 = head[c].rs1;
    assign acc_req_rs2_o[c*XLen +: XLen]                 = head[c].rs2;
    assign acc_req_trans_id_o[c*TransIdBits +: TransIdBits] = head[c].trans_id;
    assign resp_data[c*RespW +: RespW] = {acc_resp_trans_id_i[c*TransIdBits +: TransIdBits],
                                          acc_resp_result_i[c*XLen +: XLen]};

    acc_chan_queue #(.QueueDepth(QueueDepth)) u_queue (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .push_i           (push[c]),
      .push_entry_i     (issue_entry),
      .pop_i            (pop[c]),
      .load_complete_i  (acc_load_complete_i[c]),
      .store_complete_i (acc_store_complete_i[c]),
      .head_o           (head[c]),
      .head_valid_o     (head_valid[c]),
      .usage_o          (usage[c]),
      .ld_busy_o        (ld_busy[c]),
      .st_busy_o        (st_busy[c])
    );
  end

  assign acc_req_valid_o = req_valid;
  assign ld_pending_o    = |ld_busy;
  assign st_pending_o    = |st_busy;

  // Ready bits survive flush: a committed instruction is no longer speculative.
  always_comb begin
    pending_d = pending_q;
    ready_d   = ready_q;
    if (commit_hit) begin
      pending_d[commit_trans_id_i] = 1'b0;
      ready_d[commit_trans_id_i]   = 1'b1;
    end
    if (push_ok) pending_d[issue_trans_id_i] = 1'b1;
    if (flush_i) pending_d = '0;
    for (int c = 0; c < NrAcc; c++) begin
      if (pop[c]) ready_d[head[c].trans_id] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      ready_q   <= '0;
    end else begin
      pending_q <= pending_d;
      ready_q   <= ready_d;
    end
  end

  acc_rr_arb #(.NumIn(NrAcc), .DataWidth(RespW)) u_resp_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (acc_resp_valid_i),
    .data_i  (resp_data),
    .gnt_o   (acc_resp_ready_o),
    .valid_o (wb_valid_o),
    .data_o  ({wb_trans_id_o, wb_result_o})
  );

  // Queue entries carry package-fixed widths, so overrides must agree with them.
  a_cfg_widths: assert property (@(posedge clk_i)
    XLen == XLEN && TransIdBits == TRANS_ID_BITS && MemCntWidth == MEM_CNT_WIDTH);

endmodule

// File: tb/tb_acc_multi_dispatcher.sv
// Bench for acc_multi_dispatcher: directed sequences for dispatch, full queue,
// flush and counters, a vector table for response arbitration, queue scoreboards.
module tb_acc_multi_dispatcher;

  localparam int unsigned W    = 163;
  localparam int unsigned WB_W = 67;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         issue_valid_i;
  logic         issue_ready_o;
  logic [0:0]   issue_acc_id_i;
  logic [2:0]   issue_trans_id_i;
  logic [31:0]  issue_insn_i;
  logic [63:0]  issue_rs1_i, issue_rs2_i;
  logic         issue_is_load_i, issue_is_store_i;
  logic         commit_valid_i;
  logic [2:0]   commit_trans_id_i;
  logic [1:0]   acc_req_valid_o, acc_req_ready_i;
  logic [63:0]  acc_req_insn_o;
  logic [127:0] acc_req_rs1_o, acc_req_rs2_o;
  logic [5:0]   acc_req_trans_id_o;
  logic [1:0]   acc_resp_valid_i, acc_resp_ready_o;
  logic [5:0]   acc_resp_trans_id_i;
  logic [127:0] acc_resp_result_i;
  logic [1:0]   acc_load_complete_i, acc_store_complete_i;
  logic         wb_valid_o;
  logic [2:0]   wb_trans_id_o;
  logic [63:0]  wb_result_o;
  logic         ld_pending_o, st_pending_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]    exp_req0_q[$];
  logic [W-1:0]    exp_req1_q[$];
  logic [WB_W-1:0] exp_q[$];

  typedef struct {
    logic [1:0] valid;
    logic [2:0] tid0;
    logic [2:0] tid1;
    logic [1:0] exp_gnt;
    logic [2:0] exp_tid;
  } arb_vec_t;

  arb_vec_t vecs[8];

  acc_multi_dispatcher dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_acc_id_i(issue_acc_id_i), .issue_trans_id_i(issue_trans_id_i),
    .issue_insn_i(issue_insn_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_is_load_i(issue_is_load_i), .issue_is_store_i(issue_is_store_i),
    .commit_valid_i(commit_valid_i), .commit_trans_id_i(commit_trans_id_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_insn_o(acc_req_insn_o), .acc_req_rs1_o(acc_req_rs1_o),
    .acc_req_rs2_o(acc_req_rs2_o), .acc_req_trans_id_o(acc_req_trans_id_o),
    .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
    .acc_resp_trans_id_i(acc_resp_trans_id_i), .acc_resp_result_i(acc_resp_result_i),
    .acc_load_complete_i(acc_load_complete_i), .acc_store_complete_i(acc_store_complete_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .ld_pending_o(ld_pending_o), .st_pending_o(st_pending_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Driver tasks
  task automatic idle();
    flush_i = 1'b0; issue_valid_i = 1'b0; issue_acc_id_i = '0; issue_trans_id_i = '0;
    issue_insn_i = '0; issue_rs1_i = '0; issue_rs2_i = '0;
    issue_is_load_i = 1'b0; issue_is_store_i = 1'b0;
    commit_valid_i = 1'b0; commit_trans_id_i = '0; acc_req_ready_i = '0;
    acc_resp_valid_i = '0; acc_resp_trans_id_i = '0; acc_resp_result_i = '0;
    acc_load_complete_i = '0; acc_store_complete_i = '0;
  endtask

  task automatic issue(input int acc, input logic [2:0] tid, input logic [31:0] insn,
                       input logic ld, input logic st, input logic will_dispatch);
    logic [63:0] rs1, rs2;
    rs1 = {32'h0000_C0DE, insn};
    rs2 = {$urandom, $urandom};
    issue_valid_i    = 1'b1;
    issue_acc_id_i   = acc[0:0];
    issue_trans_id_i = tid;
    issue_insn_i     = insn;
    issue_rs1_i      = rs1;
    issue_rs2_i      = rs2;
    issue_is_load_i  = ld;
    issue_is_store_i = st;
    if (will_dispatch) begin
      if (acc == 0) exp_req0_q.push_back({tid, insn, rs1, rs2});
      else          exp_req1_q.push_back({tid, insn, rs1, rs2});
    end
  endtask

  task automatic commit(input logic [2:0] tid, input logic [1:0] req_ready);
    commit_valid_i    = 1'b1;
    commit_trans_id_i = tid;
    acc_req_ready_i   = req_ready;
  endtask

  // Scoreboard: request channel handshakes and writeback beats
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int c = 0; c < 2; c++) begin
        if (acc_req_valid_o[c] && acc_req_ready_i[c]) begin
          logic [W-1:0] act, expv;
          act = {acc_req_trans_id_o[c*3 +: 3], acc_req_insn_o[c*32 +: 32],
                 acc_req_rs1_o[c*64 +: 64], acc_req_rs2_o[c*64 +: 64]};
          checks++;
          if ((c == 0 && exp_req0_q.size() == 0) || (c == 1 && exp_req1_q.size() == 0)) begin
            failures++;
            $display("FAIL req_unexpected ch=%0d actual=%h expected=none", c, act);
          end else begin
            expv = (c == 0) ? exp_req0_q.pop_front() : exp_req1_q.pop_front();
            if (act !== expv) begin
              failures++;
              $display("FAIL req_payload ch=%0d actual=%h expected=%h", c, act, expv);
            end
          end
        end
      end
      if (wb_valid_o) begin
        logic [WB_W-1:0] wexp;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected actual=%h expected=none", {wb_trans_id_o, wb_result_o});
        end else begin
          wexp = exp_q.pop_front();
          if ({wb_trans_id_o, wb_result_o} !== wexp) begin
            failures++;
            $display("FAIL wb_payload actual=%h expected=%h", {wb_trans_id_o, wb_result_o}, wexp);
          end
        end
      end
    end
  end

  logic [2:0] fill_tids[4];

  initial begin
    vecs[0] = '{2'b11, 3'd1, 3'd2, 2'b01, 3'd1};
    vecs[1] = '{2'b11, 3'd3, 3'd4, 2'b10, 3'd4};
    vecs[2] = '{2'b11, 3'd5, 3'd6, 2'b01, 3'd5};
    vecs[3] = '{2'b11, 3'd7, 3'd0, 2'b10, 3'd0};
    vecs[4] = '{2'b10, 3'd1, 3'd2, 2'b10, 3'd2};
    vecs[5] = '{2'b01, 3'd3, 3'd4, 2'b01, 3'd3};
    vecs[6] = '{2'b11, 3'd5, 3'd6, 2'b10, 3'd6};
    vecs[7] = '{2'b00, 3'd0, 3'd0, 2'b00, 3'd0};
    fill_tids[0] = 3'd0; fill_tids[1] = 3'd1; fill_tids[2] = 3'd2; fill_tids[3] = 3'd4;

    idle();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    settle();
    check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst_req_valid", 64'(acc_req_valid_o), 64'd0);
    check("rst_resp_ready", 64'(acc_resp_ready_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_ld_pending", 64'(ld_pending_o), 64'd0);
    check("rst_st_pending", 64'(st_pending_o), 64'd0);
    tick();

    // Commit bypass: issue to channel 1, commit next cycle, dispatch in that cycle
    issue(1, 3'd3, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1);
    settle();
    check("t1_issue_ready", 64'(issue_ready_o), 64'd1);
    check("t1_no_req_before_commit", 64'(acc_req_valid_o), 64'd0);
    tick(); idle();
    commit(3'd3, 2'b10);
    settle();
    check("t1_bypass_valid", 64'(acc_req_valid_o), 64'b10);
    tick(); idle();
    settle();
    check("t1_popped", 64'(acc_req_valid_o), 64'd0);
    tick();

    // Fill channel 0 with uncommitted entries
    for (int k = 0; k < 4; k++) begin
      issue(0, fill_tids[k], 32'h0F00_0000 + 32'(k), 1'b0, 1'b0, 1'b1);
      settle();
      check("t2_ready_while_filling", 64'(issue_ready_o), 64'd1);
      tick(); idle();
    end
    issue(0, 3'd6, 32'hDEAD_0005, 1'b0, 1'b0, 1'b0);
    settle();
    check("t2_full_ch0", 64'(issue_ready_o), 64'd0);
    issue_acc_id_i = 1'b1;
    settle();
    check("t2_ch1_free", 64'(issue_ready_o), 64'd1);
    issue_acc_id_i = 1'b0;
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      commit(fill_tids[k], 2'b01);
      settle();
      check("t2_drain_valid", 64'(acc_req_valid_o), 64'b01);
      tick(); idle();
    end
    commit(3'd6, 2'b01);
    settle();
    check("t2_refused_absent", 64'(acc_req_valid_o), 64'd0);
    check("t2_ch0_ready_again", 64'(issue_ready_o), 64'd1);
    tick(); idle();

    // Flush speculative loads before commit
    issue(0, 3'd1, 32'h1D00_0001, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    settle();
    check("t3_ld_pending", 64'(ld_pending_o), 64'd1);
    issue(0, 3'd2, 32'h1D00_0002, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    flush_i = 1'b1;
    settle();
    check("t3_ld_pending_flush_cycle", 64'(ld_pending_o), 64'd1);
    tick(); idle();
    settle();
    check("t3_flush_clears_ld", 64'(ld_pending_o), 64'd0);
    commit(3'd1, 2'b01);
    settle();
    check("t3_no_req_after_flush", 64'(acc_req_valid_o), 64'd0);
    tick(); idle();

    // Dispatched store survives flush until its completion pulse
    issue(0, 3'd5, 32'h5700_0005, 1'b0, 1'b1, 1'b1);
    tick(); idle();
    commit(3'd5, 2'b01);
    settle();
    check("t4_store_dispatch", 64'(acc_req_valid_o), 64'b01);
    tick(); idle();
    flush_i = 1'b1;
    settle();
    check("t4_st_pending_flush", 64'(st_pending_o), 64'd1);
    tick(); idle();
    for (int j = 0; j < 3; j++) begin
      settle();
      check("t4_st_pending_hold", 64'(st_pending_o), 64'd1);
      tick();
    end
    acc_store_complete_i = 2'b01;
    settle();
    check("t4_before_pulse", 64'(st_pending_o), 64'd1);
    tick(); idle();
    settle();
    check("t4_after_pulse", 64'(st_pending_o), 64'd0);
    tick();

    // Same-cycle push and dispatch of loads on channel 0
    issue(0, 3'd1, 32'h1D00_0011, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    issue(0, 3'd2, 32'h1D00_0012, 1'b1, 1'b0, 1'b1);
    commit(3'd1, 2'b01);
    settle();
    check("t6_pop_with_push", 64'(acc_req_valid_o), 64'b01);
    tick(); idle();
    commit(3'd2, 2'b01);
    settle();
    check("t6_second_dispatch", 64'(acc_req_valid_o), 64'b01);
    tick(); idle();
    acc_load_complete_i = 2'b01;
    tick(); idle();
    settle();
    check("t6_one_outstanding", 64'(ld_pending_o), 64'd1);
    acc_load_complete_i = 2'b01;
    tick(); idle();
    settle();
    check("t6_all_complete", 64'(ld_pending_o), 64'd0);
    tick();

    // Response arbitration vectors
    for (int i = 0; i < 8; i++) begin
      logic [63:0] res0, res1;
      res0 = 64'hA000_0000_0000_0000 | 64'(i);
      res1 = 64'hB000_0000_0000_0000 | 64'(i);
      acc_resp_valid_i    = vecs[i].valid;
      acc_resp_trans_id_i = {vecs[i].tid1, vecs[i].tid0};
      acc_resp_result_i   = {res1, res0};
      if (vecs[i].exp_gnt != 2'b00)
        exp_q.push_back({vecs[i].exp_tid, (vecs[i].exp_gnt == 2'b01) ? res0 : res1});
      settle();
      check("t5_resp_ready", 64'(acc_resp_ready_o), 64'(vecs[i].exp_gnt));
      check("t5_wb_valid", 64'(wb_valid_o), 64'(vecs[i].exp_gnt != 2'b00));
      tick();
    end
    idle();
    tick();

    check("sb_req0_drained", 64'(exp_req0_q.size()), 64'd0);
    check("sb_req1_drained", 64'(exp_req1_q.size()), 64'd0);
    check("sb_wb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_multi_dispatcher.md
Name: acc_multi_dispatcher

Overview:
- Parametrised successor of the single-accelerator dispatcher. Routes issued accelerator instructions to one of NrAcc accelerator channels.
- Each channel has its own instruction queue. An instruction is released to its accelerator only once the commit stage marks its transaction ID non-speculative.
- Tracks speculative and dispatched accelerator loads/stores per channel, so the issue stage can enforce scalar/accelerator memory consistency.
- Round-robin arbitrates accelerator responses back onto a single writeback port.

Parameters:
NrAcc, 2, number of accelerator channels (>=1)
QueueDepth, 4, entries per channel instruction queue (>=2)
NrSbEntries, 8, scoreboard entries; transaction-ID space
TransIdBits, 3, $clog2(NrSbEntries)
XLen, 64, operand/result width
MemCntWidth, 3, width of each load/store counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  flush speculative state
issue_valid_i  in  1  accelerator instruction offered
issue_ready_o  out  1  addressed channel queue can accept
issue_acc_id_i  in  $clog2(NrAcc)  target channel
issue_trans_id_i  in  TransIdBits  scoreboard ID
issue_insn_i  in  32  raw instruction
issue_rs1_i / issue_rs2_i  in  XLen  operands
issue_is_load_i / issue_is_store_i  in  1  memory class
commit_valid_i  in  1  head-of-scoreboard accelerator instruction now non-speculative
commit_trans_id_i  in  TransIdBits  its ID
acc_req_valid_o  out  NrAcc  per-channel request valid
acc_req_ready_i  in  NrAcc  per-channel request ready
acc_req_insn_o  out  NrAcc*32  request instruction
acc_req_rs1_o / acc_req_rs2_o  out  NrAcc*XLen  request operands
acc_req_trans_id_o  out  NrAcc*TransIdBits  request ID
acc_resp_valid_i  in  NrAcc  response valid
acc_resp_ready_o  out  NrAcc  response accepted
acc_resp_trans_id_i  in  NrAcc*TransIdBits  response ID
acc_resp_result_i  in  NrAcc*XLen  response data
acc_load_complete_i / acc_store_complete_i  in  NrAcc  one-cycle completion pulses
wb_valid_o  out  1  writeback valid
wb_trans_id_o  out  TransIdBits  writeback ID
wb_result_o  out  XLen  writeback data
ld_pending_o / st_pending_o  out  1  any channel has a speculative or dispatched load/store

Behaviour:
- Reset (rst_i high at a clock edge): queues empty; ready/pending bitmaps zero; all counters zero; RR pointer 0. After reset, all outputs are 0 except issue_ready_o=1.
- Issue:
  - Push when issue_valid_i && issue_ready_o.
  - issue_ready_o = usage[issue_acc_id_i] < QueueDepth.
  - On push, pending[trans_id] is set.
- Queues are fall-through. A push into an empty queue is visible at the head in the same cycle.
- Commit: if commit_valid_i && pending[commit_trans_id_i], then ready[id] is set and pending[id] is cleared next cycle.
- Request valid for channel c:
  - Queue non-empty and (ready[head.id] or same-cycle commit of head.id), i.e. commit bypass with zero added latency.
  - Pop on valid && acc_req_ready_i[c]; ready[head.id] is cleared on pop.
- acc_req_*_o hold stable while valid && !ready.
- Flush:
  - Clears all queues, pending bits and speculative counters.
  - Does not clear ready bits or dispatched counters.
  - Flush wins over a same-cycle push; a same-cycle handshaked pop still completes.
- Counters per channel (saturating is illegal; assertion fires on overflow/underflow):
  - spec_ld: +1 on push of a load, -1 on dispatch of a load.
  - disp_ld: +1 on dispatch of a load, -1 on acc_load_complete_i.
  - Stores use the same pair of rules with their own counters.
  - Simultaneous inc and dec leaves the count unchanged.
- ld_pending_o / st_pending_o: OR over channels of the respective counters being nonzero, registered-state based (no combinational path from issue inputs).
- Response arbitration:
  - Round-robin over acc_resp_valid_i, starting at the RR pointer.
  - The grant is combinational; acc_resp_ready_o is one-hot, asserted to the granted channel.
  - The winner is forwarded to wb_* in the same cycle.
  - RR pointer moves to grant+1 (mod NrAcc) after each grant.
  - Responses are not flushed.
- Queue pointers wrap modulo QueueDepth; non-power-of-two depths are supported.

Decomposition:
- Package acc_multi_pkg: acc_queue_entry_t {insn, rs1, rs2, trans_id, is_load, is_store}; acc_mem_cnt_t.
- Sub-module acc_chan_queue: one channel's FIFO plus its four counters, instantiated NrAcc times.
- Arbitration uses an rr_arb_tree-style instance.

Test Plan:
- Reset then issue ID 3 to channel 1, commit ID 3 next cycle, acc_req_ready_i=2'b10 -> acc_req_valid_o[1] rises the commit cycle (bypass), insn/rs match, pop same cycle.
- Fill channel 0 with QueueDepth=4 uncommitted entries -> issue_ready_o=0 for acc_id 0, still 1 for acc_id 1; a 5th push is refused.
- Push 2 loads to channel 0, flush before commit -> spec_ld=0, ld_pending_o=0 next cycle, queue empty, no request issued.
- Dispatch store ID 5, flush, then acc_store_complete_i[0] 4 cycles later -> st_pending_o stays 1 until the cycle after the completion pulse.
- Both channels hold resp_valid for 4 cycles with RR pointer 0 -> grants 0,1,0,1; wb_trans_id_o follows; the other ready is 0 each cycle.
- Same-cycle push and dispatch of loads on one channel -> spec_ld unchanged; no overflow assertion fires.
